// File: rtl/decoder_3x8.sv
// decoder_3x8: registered 3-to-8 one-hot decoder with selectable output polarity.
// A sampled code appears on out one clock later with valid set; when disabled
// or in reset, out rests at the inactive pattern and valid is low.
module decoder_3x8 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] in,
    output logic [7:0] out,
    output logic       valid
);

    // Level driven on every line when nothing is selected.
    localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] onehot_next;
    logic [7:0] out_next;
    logic [7:0] out_reg;
    logic       valid_reg;

    // One comparator per output line: line gi is selected when the code equals gi.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            assign onehot_next[gi] = (in == 3'(gi));
        end
    endgenerate

    // Apply output polarity to the active-high one-hot vector.
    assign out_next = ACTIVE_LOW ? ~onehot_next : onehot_next;

    // Output register: reset wins over enable, disabled cycles park at the inactive pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= INACTIVE;
            valid_reg <= 1'b0;
        end else if (en) begin
            out_reg   <= out_next;
            valid_reg <= 1'b1;
        end else begin
            out_reg   <= INACTIVE;
            valid_reg <= 1'b0;
        end
    end

    assign out   = out_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_decoder_3x8.sv
// tb_decoder_3x8: directed checks of both polarities of decoder_3x8 driven by
// the same stimulus, plus a long random run checked against a one-hot model.
module tb_decoder_3x8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] sel;
    logic [7:0] out0;
    logic       valid0;
    logic [7:0] out1;
    logic       valid1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    decoder_3x8 #(.ACTIVE_LOW(1'b0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (sel),
        .out   (out0),
        .valid (valid0)
    );

    decoder_3x8 #(.ACTIVE_LOW(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (sel),
        .out   (out1),
        .valid (valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (txn %0d)", tag, got, exp, n_txn);
        end
    endtask

    // Apply one set of inputs, clock it in, and return 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] c, input bit quiet);
        rst = r;
        en  = e;
        sel = c;
        @(posedge clk);
        #1;
        n_txn++;
        if (!quiet)
            $display("txn %0d rst=%b en=%b in=%0d -> out0=%h valid0=%b out1=%h valid1=%b",
                     n_txn, r, e, c, out0, valid0, out1, valid1);
    endtask

    logic [7:0] tab0 [8];
    logic [7:0] tab1 [8];
    logic [7:0] exp0;
    logic       r_en;
    logic [2:0] r_code;

    initial begin
        tab0 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        tab1 = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        rst = 1'b1;
        en  = 1'b0;
        sel = 3'd0;

        // Reset state
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        check("rst_out0",   out0,         8'h00);
        check("rst_valid0", {7'd0, valid0}, 8'h00);
        check("rst_out1",   out1,         8'hFF);
        check("rst_valid1", {7'd0, valid1}, 8'h00);

        // Exhaustive back-to-back sweep, both polarities
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 3'(i), 1'b0);
            check("sweep_out0",   out0,           tab0[i]);
            check("sweep_valid0", {7'd0, valid0}, 8'h01);
            check("sweep_out1",   out1,           tab1[i]);
            check("sweep_valid1", {7'd0, valid1}, 8'h01);
        end

        // Enable gating
        step(1'b0, 1'b1, 3'd5, 1'b0);
        check("gate_on_out0",    out0,           8'h20);
        check("gate_on_valid0",  {7'd0, valid0}, 8'h01);
        check("gate_on_out1",    out1,           8'hDF);
        step(1'b0, 1'b0, 3'd3, 1'b0);
        check("gate_off_out0",   out0,           8'h00);
        check("gate_off_valid0", {7'd0, valid0}, 8'h00);
        check("gate_off_out1",   out1,           8'hFF);
        check("gate_off_valid1", {7'd0, valid1}, 8'h00);

        // Reset priority over a simultaneous enable, then resume
        step(1'b1, 1'b1, 3'd7, 1'b0);
        check("rstpri_out0",   out0,           8'h00);
        check("rstpri_valid0", {7'd0, valid0}, 8'h00);
        check("rstpri_out1",   out1,           8'hFF);
        step(1'b0, 1'b1, 3'd7, 1'b0);
        check("resume_out0",   out0,           8'h80);
        check("resume_valid0", {7'd0, valid0}, 8'h01);
        check("resume_out1",   out1,           8'h7F);

        // Reset mid-stream discards the pending code
        step(1'b0, 1'b1, 3'd2, 1'b0);
        check("stream_out0",   out0,           8'h04);
        step(1'b1, 1'b1, 3'd6, 1'b0);
        check("midrst_out0",   out0,           8'h00);
        check("midrst_valid0", {7'd0, valid0}, 8'h00);
        check("midrst_out1",   out1,           8'hFF);

        // Glitching input between edges must not reach out before the edge
        step(1'b0, 1'b1, 3'd3, 1'b0);
        check("pre_glitch_out0", out0, 8'h08);
        sel = 3'd2;
        #2;
        sel = 3'd6;
        #2;
        check("glitch_hold_out0", out0, 8'h08);
        check("glitch_hold_out1", out1, 8'hF7);
        sel = 3'd2;
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d glitch 010->110->010 -> out0=%h valid0=%b", n_txn, out0, valid0);
        check("glitch_out0",   out0,           8'h04);
        check("glitch_valid0", {7'd0, valid0}, 8'h01);

        // Random one-hot property run
        for (int k = 0; k < 1000; k++) begin
            r_en   = 1'($urandom_range(0, 1));
            r_code = 3'($urandom_range(0, 7));
            step(1'b0, r_en, r_code, 1'b1);
            exp0 = r_en ? (8'h01 << r_code) : 8'h00;
            check("rand_out0",   out0,                  exp0);
            check("rand_valid0", {7'd0, valid0},        {7'd0, r_en});
            check("rand_pop0",   8'($countones(out0)),  {7'd0, r_en});
            check("rand_out1",   out1,                  ~exp0);
        end
        $display("random run: 1000 transactions");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_3x8.md
DECODER_3X8 -- requirements
Module: decoder_3x8

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter ACTIVE_LOW, default 0, output polarity select: 0 means the selected line is 1; 1 means the selected line is 0 and all others are 1.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port en, input, 1 bit: decode enable, sampled on the rising edge of clk.
REQ-006 Port in, input, 3 bits: binary select code; in[2] is the MSB.
REQ-007 Port out, output, 8 bits: registered one-hot decode result.
REQ-008 Port valid, output, 1 bit: registered flag, 1 when out holds a decode of an enabled sample.

Function
REQ-009 When en=1 at a rising edge, out SHALL take value (1 << in) on that edge, i.e. out[k]=1 iff in==k, with all other bits 0 (ACTIVE_LOW=0).
REQ-010 Decode mapping SHALL be, for ACTIVE_LOW=0:
- in 000 -> out 00000001
- in 001 -> out 00000010
- in 010 -> out 00000100
- in 011 -> out 00001000
- in 100 -> out 00010000
- in 101 -> out 00100000
- in 110 -> out 01000000
- in 111 -> out 10000000
REQ-011 Latency SHALL be exactly one clock cycle from sampled in/en to out/valid; no combinational path from in or en to out or valid.
REQ-012 When en=1 at a rising edge, valid SHALL be set to 1 on that edge.
REQ-013 When en=0 at a rising edge, out SHALL be driven to the inactive pattern and valid SHALL be 0 on that edge.
- Inactive pattern: 8'h00 for ACTIVE_LOW=0; 8'hFF for ACTIVE_LOW=1.
REQ-014 With ACTIVE_LOW=1, every out value SHALL be the bitwise inverse of the ACTIVE_LOW=0 value for the same stimulus.
REQ-015 With ACTIVE_LOW=0, whenever valid=1, out SHALL have exactly one bit set; with ACTIVE_LOW=1, exactly one bit clear.
REQ-016 Back-to-back enabled codes SHALL produce back-to-back decodes, one per cycle, with no bubbles.
REQ-017 Input changes between clock edges SHALL NOT affect out until the next rising edge.
REQ-018 in and en SHALL be treated as two-state; X/Z handling is outside the required behaviour.

Reset
REQ-019 rst=1 at a rising edge SHALL force out to the inactive pattern and valid to 0, overriding en and in.
REQ-020 Reset SHALL take priority over a simultaneous en=1; no decode of that cycle's input is produced.
REQ-021 On the first rising edge with rst=0 and en=1, normal decoding SHALL resume with one-cycle latency; no state survives reset.
REQ-022 Reset asserted mid-stream SHALL clear out/valid on that edge; the pending code is discarded.

Verification
REQ-023 Exhaustive sweep, ACTIVE_LOW=0: rst released, en=1, in=000..111 one per cycle -> one cycle later out=01,02,04,08,10,20,40,80 (hex), valid=1 each cycle.
REQ-024 Exhaustive sweep, ACTIVE_LOW=1: same stimulus -> out=FE,FD,FB,F7,EF,DF,BF,7F (hex), valid=1.
REQ-025 Enable gating: en=1, in=101, then en=0, in=011 -> out=20 then 00, valid=1 then 0.
REQ-026 Reset priority: rst=1, en=1, in=111 -> out=00, valid=0; next cycle rst=0, in=111 -> out=80, valid=1.
REQ-027 Mid-cycle glitch: in toggles 010->110->010 between edges, stable 010 at the edge -> out=04, with no intermediate change on out.
REQ-028 One-hot property check over random en/in for at least 1000 cycles (ACTIVE_LOW=0):
- valid=1 implies popcount(out)==1 and out==1<<in_prev, where in_prev is in as sampled at the previous rising edge;
- valid=0 implies out==00.
